// File: rtl/transpose_buffer_pingpong_if.sv
// Handshake bundle for transpose_buffer_pingpong: the row-input side and the column-output side.
interface transpose_buffer_pingpong_if #(
  parameter int MAX_N = 32,
  parameter int DW    = 16
) ();
  logic [1:0]          size;
  logic                in_valid;
  logic                in_ready;
  logic [MAX_N*DW-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [MAX_N*DW-1:0] out_data;
  logic [1:0]          out_size;
  logic                out_last;

  modport master (
    output size, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_size, out_last
  );

  modport slave (
    input  size, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_size, out_last
  );
endinterface

// File: rtl/transpose_buffer_pingpong.sv
// Ping-pong transpose buffer: rows in, columns out, block size 4/8/16/32 chosen per block.
// Optional macro TPB_BLOCK_CNT_EN adds a 16-bit count of blocks read out (blk_cnt).
module transpose_buffer_pingpong #(
  parameter int MAX_N = 32,
  parameter int DW    = 16
) (
  input  logic clk,
  input  logic reset,
  transpose_buffer_pingpong_if.slave bus
`ifdef TPB_BLOCK_CNT_EN
  ,
  output logic [15:0] blk_cnt
`endif
);
  localparam int CW = $clog2(MAX_N);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  bank_state_t   state [2];
  bank_state_t   state_n [2];
  logic [1:0]    size_q [2];
  logic [1:0]    size_n [2];
  logic          wr_bank, wr_bank_n;
  logic          rd_bank, rd_bank_n;
  logic [CW-1:0] wr_row, wr_row_n;
  logic [CW-1:0] rd_col, rd_col_n;
  logic [CW-1:0] wr_last_idx, rd_last_idx;
  logic          wr_fire, rd_fire;
  logic [DW-1:0] mem [2][MAX_N][MAX_N];

  // Size codes beyond MAX_N are clamped so the counters can never run past the array.
  function automatic logic [CW-1:0] last_idx(input logic [1:0] code);
    int n;
    n = 4 << code;
    if (n > MAX_N) n = MAX_N;
    return CW'(n - 1);
  endfunction

  assign bus.in_ready  = (state[wr_bank] != FULL);
  assign bus.out_valid = (state[rd_bank] == FULL);
  assign wr_fire       = bus.in_valid && bus.in_ready;
  assign rd_fire       = bus.out_valid && bus.out_ready;
  // Row 0 takes its size from the live input; later rows use the latched code.
  assign wr_last_idx   = last_idx((wr_row == '0) ? bus.size : size_q[wr_bank]);
  assign rd_last_idx   = last_idx(size_q[rd_bank]);
  assign bus.out_size  = size_q[rd_bank];
  assign bus.out_last  = bus.out_valid && (rd_col == rd_last_idx);

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k <= int'(rd_last_idx))
        bus.out_data[(MAX_N-1-k)*DW +: DW] = mem[rd_bank][k][rd_col];
    end
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_n[b] = state[b];
      size_n[b]  = size_q[b];
    end
    wr_bank_n = wr_bank;
    wr_row_n  = wr_row;
    rd_bank_n = rd_bank;
    rd_col_n  = rd_col;
    if (wr_fire) begin
      if (wr_row == '0) size_n[wr_bank] = bus.size;
      if (wr_row == wr_last_idx) begin
        state_n[wr_bank] = FULL;
        wr_row_n         = '0;
        wr_bank_n        = ~wr_bank;
      end else begin
        state_n[wr_bank] = FILLING;
        wr_row_n         = wr_row + CW'(1);
      end
    end
    // Write and read always target different banks, so both updates can apply together.
    if (rd_fire) begin
      if (rd_col == rd_last_idx) begin
        state_n[rd_bank] = EMPTY;
        rd_col_n         = '0;
        rd_bank_n        = ~rd_bank;
      end else begin
        rd_col_n         = rd_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        state[b]  <= EMPTY;
        size_q[b] <= 2'b00;
      end
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_col  <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state[b]  <= state_n[b];
        size_q[b] <= size_n[b];
      end
      wr_bank <= wr_bank_n;
      rd_bank <= rd_bank_n;
      wr_row  <= wr_row_n;
      rd_col  <= rd_col_n;
    end
  end

  // Storage is never cleared; lanes beyond the block size are written but never read.
  always_ff @(posedge clk) begin
    if (wr_fire && !reset) begin
      for (int c = 0; c < MAX_N; c++)
        mem[wr_bank][wr_row][c] <= bus.in_data[(MAX_N-1-c)*DW +: DW];
    end
  end

`ifdef TPB_BLOCK_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      blk_cnt <= 16'h0000;
    else if (rd_fire && bus.out_last)
      blk_cnt <= blk_cnt + 16'h0001;
  end
`endif
endmodule

// File: tb/tb_transpose_buffer_pingpong.sv
// Randomised bench for transpose_buffer_pingpong against a block-level transpose model.
// Covers the TPB_BLOCK_CNT_EN counter when that macro is defined.
module tb_transpose_buffer_pingpong;
  localparam int MAX_N = 32;
  localparam int DW    = 16;
  localparam int W     = MAX_N * DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  transpose_buffer_pingpong_if #(.MAX_N(MAX_N), .DW(DW)) bus ();
`ifdef TPB_BLOCK_CNT_EN
  logic [15:0] blk_cnt;
`endif

  transpose_buffer_pingpong #(.MAX_N(MAX_N), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef TPB_BLOCK_CNT_EN
    ,
    .blk_cnt (blk_cnt)
`endif
  );

  // Model: rows of the block being written, then whole transposed columns awaiting readout.
  logic [W-1:0] part_rows[$];
  logic [1:0]   part_size;
  logic [W-1:0] exp_cols[$];
  logic         exp_lasts[$];
  logic [1:0]   exp_sizes[$];
  int           pend;
  logic [15:0]  model_blk;

  logic [W-1:0] stim_rows[$];
  logic [1:0]   stim_sizes[$];

  logic         obs_in_ready, obs_out_valid, obs_last;
  logic [W-1:0] obs_data;
  logic [1:0]   obs_size;
  logic         exp_in_ready, exp_out_valid, exp_last;
  logic [W-1:0] exp_data;
  logic [1:0]   exp_size;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int l = 0; l < MAX_N; l++) r[(MAX_N-1-l)*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic void push_block();
    int n;
    logic [W-1:0] row;
    logic [W-1:0] col;
    n = 4 << part_size;
    for (int c = 0; c < n; c++) begin
      col = '0;
      for (int k = 0; k < n; k++) begin
        row = part_rows[k];
        col[(MAX_N-1-k)*DW +: DW] = row[(MAX_N-1-c)*DW +: DW];
      end
      exp_cols.push_back(col);
      exp_lasts.push_back(c == n - 1);
      exp_sizes.push_back(part_size);
    end
    pend++;
    part_rows.delete();
  endfunction

  function automatic void model_clear();
    part_rows.delete();
    exp_cols.delete();
    exp_lasts.delete();
    exp_sizes.delete();
    pend      = 0;
    model_blk = 16'h0000;
  endfunction

  // Drives one cycle, samples the DUT at the negedge, then advances the model at the posedge.
  task automatic run_cycle(input logic rst, input logic vld, input logic rdy);
    logic acc, xfer;
    bus.in_valid  = vld && (stim_rows.size() > 0);
    bus.in_data   = (stim_rows.size() > 0) ? stim_rows[0] : '0;
    bus.size      = (stim_sizes.size() > 0) ? stim_sizes[0] : 2'b00;
    bus.out_ready = rdy;
    reset         = rst;
    @(negedge clk);
    obs_in_ready  = bus.in_ready;
    obs_out_valid = bus.out_valid;
    obs_last      = bus.out_last;
    obs_data      = bus.out_data;
    obs_size      = bus.out_size;
    exp_in_ready  = (pend < 2);
    exp_out_valid = (pend > 0);
    exp_data      = exp_out_valid ? exp_cols[0] : '0;
    exp_last      = exp_out_valid ? exp_lasts[0] : 1'b0;
    exp_size      = exp_out_valid ? exp_sizes[0] : 2'b00;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      acc  = bus.in_valid && exp_in_ready;
      xfer = exp_out_valid && rdy;
      if (xfer) begin
        if (exp_lasts[0]) begin
          pend--;
          model_blk = model_blk + 16'h0001;
        end
        void'(exp_cols.pop_front());
        void'(exp_lasts.pop_front());
        void'(exp_sizes.pop_front());
      end
      if (acc) begin
        if (part_rows.size() == 0) part_size = bus.size;
        part_rows.push_back(stim_rows.pop_front());
        void'(stim_sizes.pop_front());
        if (part_rows.size() == (4 << part_size)) push_block();
      end
    end
    #1;
  endtask

  task automatic queue_block(input logic [1:0] sz);
    for (int r = 0; r < (4 << sz); r++) begin
      stim_rows.push_back(rand_row());
      stim_sizes.push_back(sz);
    end
  endtask

  task automatic test_reset();
    stim_rows.delete();
    stim_sizes.delete();
    run_cycle(1'b1, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset in_ready: got %b want 1", obs_in_ready); end
    n_cmp++;
    if (obs_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset out_valid: got %b want 0", obs_out_valid); end
    n_cmp++;
    if (obs_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset out_last: got %b want 0", obs_last); end
    n_cmp++;
    if (obs_size !== 2'b00) begin n_fail++; $display("[TB] FAIL reset out_size: got %b want 00", obs_size); end
  endtask

  task automatic test_4x4();
    logic [W-1:0] row;
    int cols;
    for (int r = 0; r < 4; r++) begin
      row = rand_row();
      for (int c = 0; c < 4; c++) row[(MAX_N-1-c)*DW +: DW] = DW'(16 * r + c);
      stim_rows.push_back(row);
      stim_sizes.push_back(2'b00);
    end
    cols = 0;
    for (int cyc = 0; cyc < 40 && (stim_rows.size() > 0 || pend > 0); cyc++) begin
      run_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (obs_in_ready !== exp_in_ready) begin n_fail++; $display("[TB] FAIL 4x4 in_ready cyc %0d: got %b want %b", cyc, obs_in_ready, exp_in_ready); end
      n_cmp++;
      if (obs_out_valid !== exp_out_valid) begin n_fail++; $display("[TB] FAIL 4x4 out_valid cyc %0d: got %b want %b", cyc, obs_out_valid, exp_out_valid); end
      n_cmp++;
      if (obs_last !== exp_last) begin n_fail++; $display("[TB] FAIL 4x4 out_last cyc %0d: got %b want %b", cyc, obs_last, exp_last); end
      if (exp_out_valid) begin
        n_cmp++;
        if (obs_data !== exp_data || obs_size !== exp_size) begin
          n_fail++;
          $display("[TB] FAIL 4x4 column %0d: got %h/%b want %h/%b", cols, obs_data, obs_size, exp_data, exp_size);
        end
        cols++;
      end
    end
    n_cmp++;
    if (cols !== 4 || pend != 0) begin n_fail++; $display("[TB] FAIL 4x4 drain: got %0d columns want 4", cols); end
  endtask

  task automatic test_back_to_back();
    int cols;
    queue_block(2'b11);
    queue_block(2'b11);
    cols = 0;
    for (int cyc = 0; cyc < 200 && (stim_rows.size() > 0 || pend > 0); cyc++) begin
      run_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (obs_in_ready !== 1'b1 && stim_rows.size() > 0) begin n_fail++; $display("[TB] FAIL b2b in_ready dropped cyc %0d: got %b want 1", cyc, obs_in_ready); end
      n_cmp++;
      if (obs_out_valid !== exp_out_valid) begin n_fail++; $display("[TB] FAIL b2b out_valid cyc %0d: got %b want %b", cyc, obs_out_valid, exp_out_valid); end
      n_cmp++;
      if (obs_last !== exp_last) begin n_fail++; $display("[TB] FAIL b2b out_last cyc %0d: got %b want %b", cyc, obs_last, exp_last); end
      if (exp_out_valid) begin
        n_cmp++;
        if (obs_data !== exp_data || obs_size !== exp_size) begin
          n_fail++;
          $display("[TB] FAIL b2b column %0d: got %h/%b want %h/%b", cols, obs_data, obs_size, exp_data, exp_size);
        end
        cols++;
      end
    end
    n_cmp++;
    if (cols !== 64 || pend != 0) begin n_fail++; $display("[TB] FAIL b2b drain: got %0d columns want 64", cols); end
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 3; b++) queue_block(2'b01);
    for (int cyc = 0; cyc < 30; cyc++) begin
      run_cycle(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (obs_in_ready !== exp_in_ready) begin n_fail++; $display("[TB] FAIL stall in_ready cyc %0d: got %b want %b", cyc, obs_in_ready, exp_in_ready); end
      n_cmp++;
      if (obs_out_valid !== exp_out_valid) begin n_fail++; $display("[TB] FAIL stall out_valid cyc %0d: got %b want %b", cyc, obs_out_valid, exp_out_valid); end
      if (exp_out_valid) begin
        n_cmp++;
        if (obs_data !== exp_data || obs_last !== exp_last) begin
          n_fail++;
          $display("[TB] FAIL stall held column cyc %0d: got %h/%b want %h/%b", cyc, obs_data, obs_last, exp_data, exp_last);
        end
      end
    end
    n_cmp++;
    if (obs_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall both banks full in_ready: got %b want 0", obs_in_ready); end
    for (int cyc = 0; cyc < 100 && (stim_rows.size() > 0 || pend > 0); cyc++) begin
      run_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (obs_in_ready !== exp_in_ready) begin n_fail++; $display("[TB] FAIL release in_ready cyc %0d: got %b want %b", cyc, obs_in_ready, exp_in_ready); end
      n_cmp++;
      if (obs_last !== exp_last) begin n_fail++; $display("[TB] FAIL release out_last cyc %0d: got %b want %b", cyc, obs_last, exp_last); end
      if (exp_out_valid) begin
        n_cmp++;
        if (obs_data !== exp_data || obs_size !== exp_size) begin
          n_fail++;
          $display("[TB] FAIL release column cyc %0d: got %h/%b want %h/%b", cyc, obs_data, obs_size, exp_data, exp_size);
        end
      end
    end
    n_cmp++;
    if (stim_rows.size() != 0 || pend != 0) begin n_fail++; $display("[TB] FAIL release timeout: %0d rows %0d blocks left want 0", stim_rows.size(), pend); end
  endtask

  task automatic test_size_change();
    for (int r = 0; r < 4; r++) begin
      stim_rows.push_back(rand_row());
      stim_sizes.push_back(r < 2 ? 2'b00 : 2'b11);
    end
    queue_block(2'b11);
    for (int cyc = 0; cyc < 300 && (stim_rows.size() > 0 || pend > 0); cyc++) begin
      run_cycle(1'b0, 1'b1, 1'($urandom_range(0, 3) != 0));
      n_cmp++;
      if (obs_in_ready !== exp_in_ready) begin n_fail++; $display("[TB] FAIL sizechg in_ready cyc %0d: got %b want %b", cyc, obs_in_ready, exp_in_ready); end
      n_cmp++;
      if (obs_out_valid !== exp_out_valid) begin n_fail++; $display("[TB] FAIL sizechg out_valid cyc %0d: got %b want %b", cyc, obs_out_valid, exp_out_valid); end
      n_cmp++;
      if (obs_last !== exp_last) begin n_fail++; $display("[TB] FAIL sizechg out_last cyc %0d: got %b want %b", cyc, obs_last, exp_last); end
      if (exp_out_valid) begin
        n_cmp++;
        if (obs_data !== exp_data || obs_size !== exp_size) begin
          n_fail++;
          $display("[TB] FAIL sizechg column cyc %0d: got %h/%b want %h/%b", cyc, obs_data, obs_size, exp_data, exp_size);
        end
      end
    end
    n_cmp++;
    if (stim_rows.size() != 0 || pend != 0) begin n_fail++; $display("[TB] FAIL sizechg timeout: %0d rows %0d blocks left want 0", stim_rows.size(), pend); end
  endtask

  task automatic test_reset_midstream();
    queue_block(2'b10);
    for (int r = 0; r < 5; r++) begin
      stim_rows.push_back(rand_row());
      stim_sizes.push_back(2'b10);
    end
    for (int cyc = 0; cyc < 21; cyc++) run_cycle(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (pend != 1 || part_rows.size() != 5 || obs_out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset setup: out_valid %b want 1 (pending %0d rows %0d)", obs_out_valid, pend, part_rows.size());
    end
    stim_rows.delete();
    stim_sizes.delete();
    run_cycle(1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset out_valid: got %b want 0", obs_out_valid); end
    n_cmp++;
    if (obs_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset in_ready: got %b want 1", obs_in_ready); end
    queue_block(2'b00);
    for (int cyc = 0; cyc < 40 && (stim_rows.size() > 0 || pend > 0); cyc++) begin
      run_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (obs_out_valid !== exp_out_valid) begin n_fail++; $display("[TB] FAIL midreset4 out_valid cyc %0d: got %b want %b", cyc, obs_out_valid, exp_out_valid); end
      n_cmp++;
      if (obs_last !== exp_last) begin n_fail++; $display("[TB] FAIL midreset4 out_last cyc %0d: got %b want %b", cyc, obs_last, exp_last); end
      if (exp_out_valid) begin
        n_cmp++;
        if (obs_data !== exp_data || obs_size !== exp_size) begin
          n_fail++;
          $display("[TB] FAIL midreset4 column cyc %0d: got %h/%b want %h/%b", cyc, obs_data, obs_size, exp_data, exp_size);
        end
      end
    end
    n_cmp++;
    if (stim_rows.size() != 0 || pend != 0) begin n_fail++; $display("[TB] FAIL midreset4 timeout: %0d rows %0d blocks left want 0", stim_rows.size(), pend); end
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) queue_block(2'($urandom_range(0, 3)));
    for (int cyc = 0; cyc < 2000 && (stim_rows.size() > 0 || pend > 0); cyc++) begin
      run_cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      n_cmp++;
      if (obs_in_ready !== exp_in_ready) begin n_fail++; $display("[TB] FAIL random in_ready cyc %0d: got %b want %b", cyc, obs_in_ready, exp_in_ready); end
      n_cmp++;
      if (obs_out_valid !== exp_out_valid) begin n_fail++; $display("[TB] FAIL random out_valid cyc %0d: got %b want %b", cyc, obs_out_valid, exp_out_valid); end
      n_cmp++;
      if (obs_last !== exp_last) begin n_fail++; $display("[TB] FAIL random out_last cyc %0d: got %b want %b", cyc, obs_last, exp_last); end
      if (exp_out_valid) begin
        n_cmp++;
        if (obs_data !== exp_data || obs_size !== exp_size) begin
          n_fail++;
          $display("[TB] FAIL random column cyc %0d: got %h/%b want %h/%b", cyc, obs_data, obs_size, exp_data, exp_size);
        end
      end
    end
    n_cmp++;
    if (stim_rows.size() != 0 || pend != 0) begin n_fail++; $display("[TB] FAIL random timeout: %0d rows %0d blocks left want 0", stim_rows.size(), pend); end
  endtask

`ifdef TPB_BLOCK_CNT_EN
  task automatic test_block_cnt();
    run_cycle(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) queue_block(2'b00);
    for (int cyc = 0; cyc < 100 && (stim_rows.size() > 0 || pend > 0); cyc++) begin
      run_cycle(1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (blk_cnt !== model_blk) begin n_fail++; $display("[TB] FAIL blk_cnt cyc %0d: got %0d want %0d", cyc, blk_cnt, model_blk); end
    end
    n_cmp++;
    if (blk_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL blk_cnt after 3 blocks: got %0d want 3", blk_cnt); end
    run_cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (blk_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL blk_cnt reset: got %0d want 0", blk_cnt); end
  endtask
`endif

  initial begin
    model_clear();
    part_size     = 2'b00;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.size      = 2'b00;
    bus.out_ready = 1'b0;
    test_reset();
    test_4x4();
    test_back_to_back();
    test_backpressure();
    test_size_change();
    test_reset_midstream();
    test_random();
`ifdef TPB_BLOCK_CNT_EN
    test_block_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
